// File: rtl/vending_pkg.sv
// Shared constants and types for the single-item vending controller.
// The state names mirror the credit held, in units.
package vending_pkg;

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S5  = 2'd1,
        S10 = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NONE   = 2'd0;
    localparam logic [1:0] COIN_NICKEL = 2'd1;
    localparam logic [1:0] COIN_DIME   = 2'd2;

    localparam int PRICE        = 15;
    localparam int NICKEL_VALUE = 5;
    localparam int DIME_VALUE   = 10;

    // The reserved pattern {I,J}=01 is folded into COIN_NONE here so the FSM never sees it.
    function automatic logic [1:0] decode_coin(input logic valid, input logic kind);
        if (!valid)
            return COIN_NONE;
        else if (kind)
            return COIN_DIME;
        else
            return COIN_NICKEL;
    endfunction

endpackage

// File: rtl/vending_machine.sv
// Credit-tracking FSM for a 15-unit item; X dispenses and Y returns one nickel,
// both registered so they appear one clock after the completing coin.
module vending_machine
    import vending_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic I,
    input  logic J,
    output logic X,
    output logic Y
);

    state_t     state;
    state_t     state_next;
    logic       x_next;
    logic       y_next;
    logic [1:0] coin;

    assign coin = decode_coin(I, J);

    always_comb begin
        state_next = state;
        x_next     = 1'b0;
        y_next     = 1'b0;
        case (state)
            S0: begin
                if (coin == COIN_NICKEL)
                    state_next = S5;
                else if (coin == COIN_DIME)
                    state_next = S10;
            end
            S5: begin
                if (coin == COIN_NICKEL) begin
                    state_next = S10;
                end else if (coin == COIN_DIME) begin
                    state_next = S0;
                    x_next     = 1'b1;
                end
            end
            S10: begin
                if (coin == COIN_NICKEL) begin
                    state_next = S0;
                    x_next     = 1'b1;
                end else if (coin == COIN_DIME) begin
                    state_next = S0;
                    x_next     = 1'b1;
                    y_next     = 1'b1;
                end
            end
            // The spare encoding drops back to empty credit without a pulse.
            default: begin
                state_next = S0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
            X     <= 1'b0;
            Y     <= 1'b0;
        end else begin
            state <= state_next;
            X     <= x_next;
            Y     <= y_next;
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench: directed vector table with fixed expectations, then
// random coins checked against a credit-arithmetic reference model.
module tb_vending_machine;

    logic clk;
    logic rst;
    logic I;
    logic J;
    logic X;
    logic Y;

    int n_compared;
    int n_mismatched;

    int   model_credit;
    logic model_x;
    logic model_y;

    typedef struct {
        logic  rst;
        logic  i;
        logic  j;
        logic  x;
        logic  y;
        string name;
    } vec_t;

    vec_t vecs[$];

    vending_machine dut (
        .clk (clk),
        .rst (rst),
        .I   (I),
        .J   (J),
        .X   (X),
        .Y   (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic r, input logic i, input logic j,
                           input logic x, input logic y, input string name);
        vec_t v;
        v.rst  = r;
        v.i    = i;
        v.j    = j;
        v.x    = x;
        v.y    = y;
        v.name = name;
        vecs.push_back(v);
    endtask

    // Reference: accumulate credit in units; once it reaches the price, dispense
    // and hand back whatever exceeds it as a single nickel.
    task automatic model_step(input logic r, input logic i, input logic j);
        int value;
        if (r) begin
            model_credit = 0;
            model_x      = 1'b0;
            model_y      = 1'b0;
        end else begin
            value = i ? (j ? 10 : 5) : 0;
            model_credit += value;
            if (model_credit >= 15) begin
                model_x      = 1'b1;
                model_y      = ((model_credit - 15) == 5);
                model_credit = 0;
            end else begin
                model_x = 1'b0;
                model_y = 1'b0;
            end
        end
    endtask

    // Called at a negedge: drive, let the rising edge sample, settle past it.
    task automatic apply_stimulus(input logic r, input logic i, input logic j);
        rst = r;
        I   = i;
        J   = j;
        @(posedge clk);
        model_step(r, i, j);
        #1;
    endtask

    task automatic check_output(input string name, input logic exp_x, input logic exp_y);
        n_compared++;
        if (X !== exp_x || Y !== exp_y) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got X=%b Y=%b, expected X=%b Y=%b", name, X, Y, exp_x, exp_y);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model_credit = 0;
        model_x      = 1'b0;
        model_y      = 1'b0;
        rst = 1'b0;
        I   = 1'b0;
        J   = 1'b0;

        add_vec(1, 1, 1, 0, 0, "reset_with_dime");
        add_vec(0, 0, 0, 0, 0, "idle_after_reset");
        add_vec(0, 1, 0, 0, 0, "nickel_to_s5");
        add_vec(0, 1, 1, 1, 0, "s5_dime_dispense");
        add_vec(0, 0, 0, 0, 0, "pulse_one_cycle");
        add_vec(0, 1, 0, 0, 0, "second_nickel");
        add_vec(0, 1, 1, 1, 0, "second_dispense");
        add_vec(0, 1, 0, 0, 0, "third_nickel");
        add_vec(0, 0, 0, 0, 0, "hold_s5");
        add_vec(0, 0, 1, 0, 0, "reserved_in_s5");
        add_vec(0, 1, 1, 1, 0, "probe_s5_kept");
        add_vec(0, 1, 1, 0, 0, "dime_to_s10");
        add_vec(0, 1, 0, 1, 0, "s10_nickel_dispense");
        add_vec(0, 1, 1, 0, 0, "dime_to_s10_b");
        add_vec(0, 1, 1, 1, 1, "s10_dime_change");
        add_vec(0, 0, 0, 0, 0, "change_one_cycle");
        add_vec(0, 1, 1, 0, 0, "held_dime_1");
        add_vec(0, 1, 1, 1, 1, "held_dime_2");
        add_vec(0, 1, 1, 0, 0, "held_dime_3");
        add_vec(0, 1, 1, 1, 1, "held_dime_4");
        add_vec(0, 1, 0, 0, 0, "mid_nickel_1");
        add_vec(0, 1, 0, 0, 0, "mid_nickel_2");
        add_vec(1, 0, 0, 0, 0, "mid_reset");
        add_vec(0, 1, 0, 0, 0, "after_reset_nickel");
        add_vec(0, 1, 1, 1, 0, "probe_credit_lost");
        add_vec(0, 1, 1, 0, 0, "dime_to_s10_c");
        add_vec(0, 0, 1, 0, 0, "reserved_in_s10");
        add_vec(0, 1, 0, 1, 0, "probe_s10_kept");
        add_vec(0, 0, 1, 0, 0, "reserved_in_s0");
        add_vec(0, 1, 0, 0, 0, "probe_s0_nickel");
        add_vec(0, 1, 1, 1, 0, "probe_s0_kept");
        add_vec(0, 1, 0, 0, 0, "pre_reset_nickel");
        add_vec(1, 1, 1, 0, 0, "reset_beats_dime");
        add_vec(0, 1, 1, 0, 0, "dime_was_discarded");
        add_vec(0, 1, 0, 1, 0, "probe_after_discard");
        add_vec(0, 0, 0, 0, 0, "final_idle");

        @(negedge clk);
        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].rst, vecs[k].i, vecs[k].j);
            check_output(vecs[k].name, vecs[k].x, vecs[k].y);
            @(negedge clk);
        end

        // Random phase: occasional resets, every coin pattern including reserved.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("random_start_reset", model_x, model_y);
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            logic r;
            logic i;
            logic j;
            r = ($urandom_range(0, 19) == 0);
            i = $urandom_range(0, 1);
            j = $urandom_range(0, 1);
            apply_stimulus(r, i, j);
            check_output("random_vs_model", model_x, model_y);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/vending_machine.md
Name: vending_machine

Overview:
- Coin-operated vending controller for a single item priced at 15 units.
- Accepts nickels (5) and dimes (10) through a two-bit coin interface.
- Tracks credit in a small FSM and pulses a dispense output and a change output.
- Leaf block. Sits between the coin-acceptor front end and the dispense/change actuators.

Parameters:
- None. Price (15), nickel value (5) and dime value (10) are fixed constants.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk
- I  input  1  coin-valid: 1 = a coin is presented this cycle
- J  input  1  coin type, meaningful only when I=1: 0 = nickel (5), 1 = dime (10)
- X  output  1  dispense pulse: item released
- Y  output  1  change pulse: return one nickel (5)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Coin decode, sampled every rising edge:
  - {I,J}=00: no coin.
  - {I,J}=10: nickel.
  - {I,J}=11: dime.
  - {I,J}=01: reserved, treated as no coin.
- Coin counting is level-based. Each rising edge with I=1 counts as one coin, so a coin held for N cycles counts N times. The upstream acceptor guarantees one-cycle coin strobes.
- States, one per credit value: S0 (0), S5 (5), S10 (10).
- Transitions on each rising edge when not in reset:
  - S0: no coin -> S0; nickel -> S5; dime -> S10.
  - S5: no coin -> S5; nickel -> S10; dime -> S0 with X=1.
  - S10: no coin -> S10; nickel -> S0 with X=1; dime -> S0 with X=1, Y=1.
- Outputs are registered:
  - X and Y rise one clock after the edge that samples the completing coin.
  - Each stays high for exactly one cycle. The next edge clears it unless that edge also completes a purchase.
  - Back-to-back purchases produce X high on consecutive cycles.
  - Y is never high without X.
  - X=Y=0 on every edge where no purchase completes.
- Reset:
  - When rst=1 at a rising edge: state -> S0, X=0, Y=0.
  - Reset has priority over any coin sampled on the same edge; that coin is discarded.
  - Reset mid-transaction discards accumulated credit with no refund and no change pulse.
- There is no illegal state reachable. The encoding's unused code, if any, must recover to S0 on the next edge with X=Y=0.

Decomposition:
- Shared package vending_pkg:
  - state enum: S0, S5, S10.
  - coin-type localparams: COIN_NONE, COIN_NICKEL, COIN_DIME.
  - a value constant PRICE=15.
- A tiny combinational coin decoder is implemented inline. No sub-module is warranted.
- Structure: next-state/output combinational block plus one registered block for state, X and Y.

Test Plan:
- Reset: assert rst for one edge with {I,J}=11 -> state S0, X=0, Y=0; the dime is not credited.
- Nickel then dime, one cycle each ({I,J}=10 then 11) -> X=1, Y=0 for exactly one cycle after the dime edge. A further nickel then dime repeats the pulse, and a third nickel (with no dime) leaves state at S5.
- Dime then nickel (11, then 10) -> X=1, Y=0 one cycle after the nickel edge; state returns to S0.
- Dime, dime (11, 11 on consecutive edges) -> X=1, Y=1 for one cycle after the second dime edge.
- Held dime for 4 edges from S0 -> credits S10, then X=1/Y=1, then S10, then X=1/Y=1 again. Confirms level-based counting.
- Mid-transaction reset: nickel, nickel (S10), then rst for one edge, then nickel -> state S5, no X or Y pulse at any point. Also check that {I,J}=01 in any state leaves state unchanged with X=Y=0.
